mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 115 +++++++++++
 tb/tb_mul_div_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Sequential 8-bit multiply (shift-add) / divide (restoring) unit.
// One iteration per cycle; results and flags are held until the next completion.
module mul_div_unit (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_a,
  output logic [7:0] o_b,
  output logic       o_desC,
  output logic       o_desOv
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  logic        op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [3:0]  cnt_q;
  logic [15:0] acc_q;
  logic [8:0]  rem_q;

  logic [15:0] acc_d;
  logic [8:0]  rem_d;
  logic [8:0]  mul_sum;
  logic [9:0]  div_shift;
  logic [8:0]  div_sub;
  logic        div_neg;

  // MUL: acc = {partial product, remaining multiplier bits}.
  // DIV: acc[7:0] holds the dividend shifting out MSB first while quotient bits shift in.
  always_comb begin
    mul_sum   = {1'b0, acc_q[15:8]} + {1'b0, (acc_q[0] ? a_q : 8'h00)};
    div_shift = {rem_q, acc_q[7]};
    div_neg   = (div_shift < {2'b00, b_q});
    div_sub   = div_shift[8:0] - {1'b0, b_q};
    acc_d     = acc_q;
    rem_d     = rem_q;
    if (op_q) begin
      rem_d = div_neg ? div_shift[8:0] : div_sub;
      acc_d = {acc_q[15:8], acc_q[6:0], ~div_neg};
    end else begin
      acc_d = {mul_sum, acc_q[7:1]};
    end
  end

  assign o_desC = 1'b0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      cnt_q   <= 4'd0;
      acc_q   <= 16'h0000;
      rem_q   <= 9'h000;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_a     <= 8'h00;
      o_b     <= 8'h00;
      o_desOv <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_q)
        RUN: begin
          acc_q <= acc_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_q <= DONE;
            o_done  <= 1'b1;
            o_a     <= acc_d[7:0];
            if (op_q) begin
              o_b     <= rem_d[7:0];
              o_desOv <= 1'b0;
            end else begin
              o_b     <= acc_d[15:8];
              o_desOv <= |acc_d[15:8];
            end
          end
        end
        default: begin
          if (i_start) begin
            op_q   <= i_op;
            a_q    <= i_a;
            b_q    <= i_b;
            cnt_q  <= 4'd0;
            rem_q  <= 9'h000;
            acc_q  <= {8'h00, (i_op ? i_a : i_b)};
            o_busy <= 1'b1;
            if (i_op && (i_b == 8'h00)) begin
              state_q <= DONE;
              o_done  <= 1'b1;
              o_a     <= 8'hFF;
              o_b     <= i_a;
              o_desOv <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end else begin
            state_q <= IDLE;
            o_busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: arithmetic reference model checked every cycle,
// plus directed vectors with literal results and latencies.
module tb_mul_div_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       op = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, o_c, o_ov;
  logic [7:0] o_a, o_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  mul_div_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_a(a), .i_b(b), .o_busy(busy), .o_done(done),
    .o_a(o_a), .o_b(o_b), .o_desC(o_c), .o_desOv(o_ov)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference result {ov, b, a} from plain arithmetic.
  function automatic logic [16:0] ref_result(input logic op_v, input logic [7:0] a_v, input logic [7:0] b_v);
    int p;
    if (!op_v) begin
      p = int'(a_v) * int'(b_v);
      return {(p > 255), p[15:8], p[7:0]};
    end else if (b_v == 8'h00) begin
      return {1'b1, a_v, 8'hFF};
    end else begin
      return {1'b0, a_v % b_v, a_v / b_v};
    end
  endfunction

  // Timeline model: a request accepted while not running completes 8 edges later
  // (or at once for divide by zero); starts during a run are ignored.
  logic        m_busy = 1'b0, m_done = 1'b0, m_ov = 1'b0;
  logic [7:0]  m_a = 8'h00, m_b = 8'h00;
  logic [16:0] pend = '0;
  int          m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_ov <= 1'b0;
      m_a <= 8'h00; m_b <= 8'h00; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 1) begin
        m_left <= m_left - 1;
      end else if (m_left == 1) begin
        m_left <= 0;
        m_done <= 1'b1;
        {m_ov, m_b, m_a} <= pend;
      end else if (start) begin
        m_busy <= 1'b1;
        if (op && b == 8'h00) begin
          m_done <= 1'b1;
          {m_ov, m_b, m_a} <= ref_result(op, a, b);
        end else begin
          pend   <= ref_result(op, a, b);
          m_left <= 8;
        end
      end else begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("cycle {busy,done,c,ov,a,b}", {12'h0, busy, done, o_c, o_ov, o_a, o_b},
          {12'h0, m_busy, m_done, 1'b0, m_ov, m_a, m_b});
  end

  task automatic run_op(input string name, input logic op_v, input logic [7:0] a_v, input logic [7:0] b_v,
                        input logic [7:0] ea, input logic [7:0] eb, input logic eov, input int elat);
    int n;
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~op_v; a = 8'($urandom); b = 8'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    check({name, " latency"}, n, elat);
    check({name, " o_a"}, o_a, ea);
    check({name, " o_b"}, o_b, eb);
    check({name, " o_desOv"}, o_ov, eov);
    check({name, " o_desC"}, o_c, 1'b0);
    $display("txn %s op=%0d a=%02h b=%02h -> o_a=%02h o_b=%02h ov=%0d lat=%0d",
             name, op_v, a_v, b_v, o_a, o_b, o_ov, n);
  endtask

  initial begin
    int  n;
    logic dropped;
    #1 rst_n = 1'b0;
    #2 check("async reset outputs", {busy, done, o_c, o_ov, o_a, o_b}, 20'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op("mul 50*a0", 1'b0, 8'h50, 8'hA0, 8'h00, 8'h32, 1'b1, 9);
    run_op("mul 0f*11", 1'b0, 8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0, 9);
    run_op("mul 10*10", 1'b0, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1, 9);
    run_op("mul 00*37", 1'b0, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 9);
    run_op("div fb/12", 1'b1, 8'hFB, 8'h12, 8'h0D, 8'h11, 1'b0, 9);
    run_op("div 37/00", 1'b1, 8'h37, 8'h00, 8'hFF, 8'h37, 1'b1, 1);
    run_op("div ff/01", 1'b1, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b0, 9);
    run_op("div 05/07", 1'b1, 8'h05, 8'h07, 8'h00, 8'h05, 1'b0, 9);
    run_op("div ff/ff", 1'b1, 8'hFF, 8'hFF, 8'h01, 8'h00, 1'b0, 9);
    run_op("div 00/00", 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1, 1);

    // Back-to-back: start ignored during RUN, accepted in the DONE cycle.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'h03; b = 8'h04;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 8'h09; b = 8'h00;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b first o_done", done, 1'b1);
    check("b2b first o_a", o_a, 8'h0C);
    check("b2b first o_b", o_b, 8'h00);
    $display("txn b2b first mul 03*04 -> o_a=%02h o_b=%02h", o_a, o_b);
    start = 1'b1; op = 1'b1; a = 8'h64; b = 8'h0A;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    dropped = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!busy) dropped = 1'b1;
    end while (!done && n < 20);
    check("b2b second latency", n, 9);
    check("b2b second o_a", o_a, 8'h0A);
    check("b2b second o_b", o_b, 8'h00);
    check("b2b busy held", dropped, 1'b0);
    $display("txn b2b second div 64/0a -> o_a=%02h o_b=%02h lat=%0d", o_a, o_b, n);

    // Reset in the middle of a run aborts it.
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("mid-run reset outputs", {busy, done, o_c, o_ov, o_a, o_b}, 20'h0);
    $display("txn reset mid-run -> busy=%0d o_a=%02h o_b=%02h", busy, o_a, o_b);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op("mul ff*ff", 1'b0, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b1, 9);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
